// File: rtl/melody_sequencer.sv
// Melody sequencer: walks a fixed note/duration ROM and drives the tone
// generator's note select, timing notes and gaps in tempo ticks built from the sample enable.
module melody_sequencer #(
    parameter int TICK_DIV  = 4170,
    parameter int GAP_TICKS = 1,
    parameter int LEN       = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ena,
    input  logic       start,
    input  logic       stop,
    input  logic       loop,
    output logic [2:0] f_ent,
    output logic       busy,
    output logic [3:0] step,
    output logic       done
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_PLAY = 2'd1;
    localparam logic [1:0] S_GAP  = 2'd2;

    localparam logic [15:0] TICK_MAX = 16'(TICK_DIV - 1);
    localparam logic [4:0]  GAP_LEN  = 5'(GAP_TICKS);
    localparam logic [4:0]  ROM_LEN  = 5'(LEN);

    // Entry format {note[2:0], dur[4:0]}; dur == 0 marks the end of the pattern.
    function automatic logic [7:0] rom_init(input int idx);
        case (idx)
            0:       rom_init = {3'd1, 5'd4};
            1:       rom_init = {3'd2, 5'd4};
            2:       rom_init = {3'd3, 5'd4};
            3:       rom_init = {3'd4, 5'd4};
            4:       rom_init = {3'd3, 5'd2};
            5:       rom_init = {3'd2, 5'd2};
            6:       rom_init = {3'd1, 5'd8};
            default: rom_init = 8'd0;
        endcase
    endfunction

    logic [7:0] rom [16];

    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_rom
            assign rom[gi] = rom_init(gi);
        end
    endgenerate

    logic [1:0]  state_reg, state_next;
    logic [3:0]  step_reg, step_next;
    logic [15:0] tick_cnt_reg, tick_cnt_next;
    logic [4:0]  dur_cnt_reg, dur_cnt_next;
    logic [2:0]  f_ent_reg, f_ent_next;
    logic        busy_reg, busy_next;
    logic        done_reg, done_next;

    logic        tick;
    logic        do_eval;
    logic [4:0]  eval_idx;

    assign tick = ena && (tick_cnt_reg == TICK_MAX);

    always_comb begin
        state_next    = state_reg;
        step_next     = step_reg;
        tick_cnt_next = tick_cnt_reg;
        dur_cnt_next  = dur_cnt_reg;
        f_ent_next    = f_ent_reg;
        busy_next     = busy_reg;
        done_next     = 1'b0;
        do_eval       = 1'b0;
        eval_idx      = 5'd0;

        if (stop) begin
            state_next    = S_IDLE;
            step_next     = 4'd0;
            tick_cnt_next = 16'd0;
            dur_cnt_next  = 5'd0;
            f_ent_next    = 3'd0;
            busy_next     = 1'b0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        do_eval       = 1'b1;
                        eval_idx      = 5'd0;
                        tick_cnt_next = 16'd0;
                    end
                end
                S_PLAY, S_GAP: begin
                    if (ena) begin
                        tick_cnt_next = tick ? 16'd0 : tick_cnt_reg + 16'd1;
                    end
                    // A zero count only arises from looping onto an end marker at step 0.
                    if (dur_cnt_reg == 5'd0) begin
                        do_eval  = 1'b1;
                        eval_idx = {1'b0, step_reg};
                    end else if (tick) begin
                        if (dur_cnt_reg == 5'd1) begin
                            if (state_reg == S_PLAY && GAP_TICKS > 0) begin
                                state_next   = S_GAP;
                                dur_cnt_next = GAP_LEN;
                                f_ent_next   = 3'd0;
                            end else begin
                                do_eval  = 1'b1;
                                eval_idx = {1'b0, step_reg} + 5'd1;
                            end
                        end else begin
                            dur_cnt_next = dur_cnt_reg - 5'd1;
                        end
                    end
                end
                default: begin
                    state_next = S_IDLE;
                end
            endcase

            if (do_eval) begin
                if (eval_idx >= ROM_LEN || rom[eval_idx[3:0]][4:0] == 5'd0) begin
                    done_next = 1'b1;
                    step_next = 4'd0;
                    if (loop) begin
                        state_next   = S_PLAY;
                        dur_cnt_next = rom[0][4:0];
                        f_ent_next   = (rom[0][4:0] != 5'd0) ? rom[0][7:5] : 3'd0;
                        busy_next    = 1'b1;
                    end else begin
                        state_next   = S_IDLE;
                        dur_cnt_next = 5'd0;
                        f_ent_next   = 3'd0;
                        busy_next    = 1'b0;
                    end
                end else begin
                    state_next   = S_PLAY;
                    step_next    = eval_idx[3:0];
                    dur_cnt_next = rom[eval_idx[3:0]][4:0];
                    f_ent_next   = rom[eval_idx[3:0]][7:5];
                    busy_next    = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= S_IDLE;
            step_reg     <= 4'd0;
            tick_cnt_reg <= 16'd0;
            dur_cnt_reg  <= 5'd0;
            f_ent_reg    <= 3'd0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            step_reg     <= step_next;
            tick_cnt_reg <= tick_cnt_next;
            dur_cnt_reg  <= dur_cnt_next;
            f_ent_reg    <= f_ent_next;
            busy_reg     <= busy_next;
            done_reg     <= done_next;
        end
    end

    assign f_ent = f_ent_reg;
    assign busy  = busy_reg;
    assign step  = step_reg;
    assign done  = done_reg;
endmodule

// File: tb/tb_melody_sequencer.sv
// Bench for melody_sequencer: three parameterisations share one stimulus bus and
// are checked against a phase-level model that counts enable pulses per note/gap.
module tb_melody_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ena = 1'b1;
    logic start = 1'b0;
    logic stop = 1'b0;
    logic loop = 1'b0;

    logic [2:0] f_a, f_b, f_c;
    logic       busy_a, busy_b, busy_c;
    logic [3:0] step_a, step_b, step_c;
    logic       done_a, done_b, done_c;

    melody_sequencer #(.TICK_DIV(4), .GAP_TICKS(1), .LEN(16)) u_a (
        .clk(clk), .rst(rst), .ena(ena), .start(start), .stop(stop), .loop(loop),
        .f_ent(f_a), .busy(busy_a), .step(step_a), .done(done_a));
    melody_sequencer #(.TICK_DIV(4), .GAP_TICKS(0), .LEN(16)) u_b (
        .clk(clk), .rst(rst), .ena(ena), .start(start), .stop(stop), .loop(loop),
        .f_ent(f_b), .busy(busy_b), .step(step_b), .done(done_b));
    melody_sequencer #(.TICK_DIV(2), .GAP_TICKS(1), .LEN(16)) u_c (
        .clk(clk), .rst(rst), .ena(ena), .start(start), .stop(stop), .loop(loop),
        .f_ent(f_c), .busy(busy_c), .step(step_c), .done(done_c));

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;

    // Model: which DUT is under test, its timing, and the current phase.
    int sel_dut;
    int m_td, m_gap, m_step, m_rem;
    bit m_busy, m_in_gap, m_done;

    function automatic int mdur(input int s);
        case (s)
            0, 1, 2, 3: return 4;
            4, 5:       return 2;
            6:          return 8;
            default:    return 0;
        endcase
    endfunction

    function automatic int mnote(input int s);
        case (s)
            0, 6:    return 1;
            1, 5:    return 2;
            2, 4:    return 3;
            3:       return 4;
            default: return 0;
        endcase
    endfunction

    // Packed view {f_ent, busy, step, done}.
    function automatic logic [8:0] obs(input int sel);
        case (sel)
            0:       return {f_a, busy_a, step_a, done_a};
            1:       return {f_b, busy_b, step_b, done_b};
            default: return {f_c, busy_c, step_c, done_c};
        endcase
    endfunction

    function automatic logic [8:0] expv();
        logic [2:0] f;
        f = (m_busy && !m_in_gap) ? 3'(mnote(m_step)) : 3'd0;
        return {f, m_busy, 4'(m_step), m_done};
    endfunction

    task automatic model_reset();
        m_busy = 0; m_in_gap = 0; m_done = 0; m_step = 0; m_rem = 0;
    endtask

    task automatic model_eval(input int s);
        if (s >= 16 || mdur(s) == 0) begin
            m_done = 1;
            m_step = 0;
            m_in_gap = 0;
            if (loop) begin
                m_busy = 1;
                m_rem = mdur(0) * m_td;
            end else begin
                m_busy = 0;
            end
        end else begin
            m_busy = 1;
            m_step = s;
            m_in_gap = 0;
            m_rem = mdur(s) * m_td;
        end
    endtask

    task automatic model_clock();
        m_done = 0;
        if (stop) begin
            m_busy = 0; m_step = 0; m_in_gap = 0;
        end else if (!m_busy) begin
            if (start) model_eval(0);
        end else if (ena) begin
            m_rem--;
            if (m_rem == 0) begin
                if (!m_in_gap && m_gap > 0) begin
                    m_in_gap = 1;
                    m_rem = m_gap * m_td;
                end else begin
                    model_eval(m_step + 1);
                end
            end
        end
    endtask

    task automatic step_clk();
        @(posedge clk);
        if (rst) model_reset();
        else model_clock();
        #1;
    endtask

    task automatic do_reset(input int sel);
        sel_dut = sel;
        m_td = (sel == 2) ? 2 : 4;
        m_gap = (sel == 1) ? 0 : 1;
        rst = 1; start = 0; stop = 0; loop = 0; ena = 1;
        step_clk();
        step_clk();
        rst = 0;
    endtask

    task automatic test_reset();
        logic [8:0] got;
        do_reset(0);
        for (int s = 0; s < 3; s++) begin
            got = obs(s);
            n_checks++;
            if (got !== 9'd0) begin
                n_fail++;
                $display("FAIL reset_state dut%0d: got %h, expected %h", s, got, 9'd0);
            end
        end
        start = 1; step_clk(); start = 0;
        for (int i = 0; i < 20; i++) step_clk();
        got = obs(0);
        n_checks++;
        if (got !== expv()) begin
            n_fail++;
            $display("FAIL pre_reset_play: got %h, expected %h", got, expv());
        end
        #3 rst = 1;
        #1;
        model_reset();
        got = obs(0);
        n_checks++;
        if (got !== 9'd0) begin
            n_fail++;
            $display("FAIL async_reset: got %h, expected %h", got, 9'd0);
        end
        step_clk(); step_clk(); rst = 0;
        for (int i = 0; i < 12; i++) begin
            step_clk();
            got = obs(0);
            n_checks++;
            if (got !== 9'd0) begin
                n_fail++;
                $display("FAIL reset_hold cyc%0d: got %h, expected %h", i, got, 9'd0);
            end
        end
        $display("test_reset: async reset mid-playback done");
    endtask

    task automatic test_full_playback();
        int exp_val[14] = '{1, 0, 2, 0, 3, 0, 4, 0, 3, 0, 2, 0, 1, 0};
        int exp_len[14] = '{16, 4, 16, 4, 16, 4, 16, 4, 8, 4, 8, 4, 32, 4};
        int run_val[$];
        int run_len[$];
        logic [2:0] cur_val;
        int cur_len, n_done;
        bit ended;
        logic [8:0] got;
        do_reset(0);
        start = 1; step_clk(); start = 0;
        got = obs(0);
        n_checks++;
        if (got !== expv()) begin
            n_fail++;
            $display("FAIL full_first: got %h, expected %h", got, expv());
        end
        cur_val = got[8:6]; cur_len = 1; n_done = 0; ended = 0;
        for (int c = 1; c < 400 && !ended; c++) begin
            step_clk();
            got = obs(0);
            n_checks++;
            if (got !== expv()) begin
                n_fail++;
                $display("FAIL full_trace cyc%0d: got %h, expected %h", c, got, expv());
            end
            if (got[0]) n_done++;
            if (got[5]) begin
                if (got[8:6] == cur_val) cur_len++;
                else begin
                    run_val.push_back(int'(cur_val)); run_len.push_back(cur_len);
                    cur_val = got[8:6]; cur_len = 1;
                end
            end else begin
                run_val.push_back(int'(cur_val)); run_len.push_back(cur_len);
                ended = 1;
            end
        end
        n_checks++;
        if (!ended) begin
            n_fail++;
            $display("FAIL full_timeout: busy still %0b, expected 0", got[5]);
        end
        n_checks++;
        if (run_val.size() != 14) begin
            n_fail++;
            $display("FAIL full_phase_count: got %0d, expected 14", run_val.size());
        end else begin
            for (int i = 0; i < 14; i++) begin
                n_checks++;
                if (run_val[i] != exp_val[i] || run_len[i] != exp_len[i]) begin
                    n_fail++;
                    $display("FAIL full_phase%0d: got f=%0d len=%0d, expected f=%0d len=%0d",
                             i, run_val[i], run_len[i], exp_val[i], exp_len[i]);
                end
            end
        end
        n_checks++;
        if ({got[5], got[4:1], got[0]} !== {1'b0, 4'd0, 1'b1}) begin
            n_fail++;
            $display("FAIL full_end_state: got %h, expected busy=0 step=0 done=1", got);
        end
        step_clk();
        got = obs(0);
        n_checks++;
        if (got !== 9'd0 || n_done != 1) begin
            n_fail++;
            $display("FAIL full_after_done: got %h dones=%0d, expected 000 dones=1", got, n_done);
        end
        $display("test_full_playback: %0d phases observed", run_val.size());
    endtask

    task automatic test_looping();
        int n_done, busy_low;
        logic [8:0] got;
        do_reset(1);
        loop = 1;
        start = 1; step_clk(); start = 0;
        n_done = 0; busy_low = 0;
        for (int c = 1; c <= 400 && n_done < 3; c++) begin
            step_clk();
            got = obs(1);
            n_checks++;
            if (got !== expv()) begin
                n_fail++;
                $display("FAIL loop_trace cyc%0d: got %h, expected %h", c, got, expv());
            end
            if (!got[5]) busy_low++;
            if (got[0]) begin
                n_done++;
                n_checks++;
                if (c != 112 * n_done || got[8:6] !== 3'd1 || got[4:1] !== 4'd0) begin
                    n_fail++;
                    $display("FAIL loop_wrap%0d: got cyc=%0d f=%0d step=%0d, expected cyc=%0d f=1 step=0",
                             n_done, c, got[8:6], got[4:1], 112 * n_done);
                end
            end
        end
        n_checks++;
        if (n_done != 3 || busy_low != 0) begin
            n_fail++;
            $display("FAIL loop_passes: got dones=%0d idle_cycles=%0d, expected 3 and 0", n_done, busy_low);
        end
        loop = 0;
        for (int c = 0; c < 200 && m_busy; c++) begin
            step_clk();
            got = obs(1);
            n_checks++;
            if (got !== expv()) begin
                n_fail++;
                $display("FAIL loop_exit cyc%0d: got %h, expected %h", c, got, expv());
            end
        end
        $display("test_looping: %0d wraps", n_done);
    endtask

    task automatic test_stop();
        logic [8:0] got;
        do_reset(0);
        start = 1; step_clk(); start = 0;
        for (int i = 0; i < 200 && !(m_busy && m_step == 2 && !m_in_gap); i++) step_clk();
        step_clk(); step_clk(); step_clk();
        stop = 1; step_clk(); stop = 0;
        got = obs(0);
        n_checks++;
        if (got !== 9'd0) begin
            n_fail++;
            $display("FAIL stop_play: got %h, expected %h", got, 9'd0);
        end
        for (int i = 0; i < 5; i++) begin
            step_clk();
            got = obs(0);
            n_checks++;
            if (got !== 9'd0) begin
                n_fail++;
                $display("FAIL stop_idle cyc%0d: got %h, expected %h", i, got, 9'd0);
            end
        end
        start = 1; step_clk(); start = 0;
        got = obs(0);
        n_checks++;
        if (got !== {3'd1, 1'b1, 4'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL stop_restart: got %h, expected %h", got, {3'd1, 1'b1, 4'd0, 1'b0});
        end
        for (int i = 0; i < 200 && !m_in_gap; i++) step_clk();
        step_clk();
        stop = 1; step_clk(); stop = 0;
        got = obs(0);
        n_checks++;
        if (got !== 9'd0) begin
            n_fail++;
            $display("FAIL stop_gap: got %h, expected %h", got, 9'd0);
        end
        step_clk();
        got = obs(0);
        n_checks++;
        if (got !== 9'd0) begin
            n_fail++;
            $display("FAIL stop_no_done: got %h, expected %h", got, 9'd0);
        end
        $display("test_stop: stop in note and gap");
    endtask

    task automatic test_enable_gating();
        logic [8:0] got;
        logic [2:0] prev_f;
        int f1_cycles, ena_cnt;
        do_reset(2);
        start = 1; ena = 1; step_clk(); start = 0;
        got = obs(2);
        prev_f = got[8:6];
        f1_cycles = (got[8:6] == 3'd1) ? 1 : 0;
        ena_cnt = 0;
        for (int k = 1; k <= 40; k++) begin
            ena = (k % 3 == 0);
            step_clk();
            if (prev_f == 3'd1 && ena) ena_cnt++;
            got = obs(2);
            n_checks++;
            if (got !== expv()) begin
                n_fail++;
                $display("FAIL gate_trace cyc%0d: got %h, expected %h", k, got, expv());
            end
            if (got[8:6] == 3'd1 && got[4:1] == 4'd0) f1_cycles++;
            prev_f = got[8:6];
        end
        n_checks++;
        if (f1_cycles != 24 || ena_cnt != 8) begin
            n_fail++;
            $display("FAIL gate_step0_len: got %0d cycles %0d enas, expected 24 cycles 8 enas", f1_cycles, ena_cnt);
        end
        ena = 0;
        for (int i = 0; i < 50; i++) begin
            step_clk();
            got = obs(2);
            n_checks++;
            if (got[8:6] !== 3'd2 || got[4:1] !== 4'd1 || got !== expv()) begin
                n_fail++;
                $display("FAIL gate_freeze cyc%0d: got %h, expected %h", i, got, expv());
            end
        end
        for (int k = 1; k < 900 && m_busy; k++) begin
            ena = (k % 3 == 0);
            step_clk();
            got = obs(2);
            n_checks++;
            if (got !== expv()) begin
                n_fail++;
                $display("FAIL gate_resume cyc%0d: got %h, expected %h", k, got, expv());
            end
        end
        ena = 1;
        $display("test_enable_gating: step0 %0d cycles, %0d enas", f1_cycles, ena_cnt);
    endtask

    task automatic test_priority();
        logic [8:0] got;
        logic [3:0] last_step;
        int seq[$];
        do_reset(0);
        start = 1; stop = 1; step_clk(); start = 0; stop = 0;
        for (int i = 0; i < 5; i++) begin
            step_clk();
            got = obs(0);
            n_checks++;
            if (got !== 9'd0) begin
                n_fail++;
                $display("FAIL prio_both_high cyc%0d: got %h, expected %h", i, got, 9'd0);
            end
        end
        start = 1; step_clk(); start = 0;
        last_step = 4'd0;
        seq.push_back(0);
        for (int i = 0; i < 300 && m_busy; i++) begin
            start = ($urandom_range(0, 5) == 0);
            step_clk();
            got = obs(0);
            n_checks++;
            if (got !== expv()) begin
                n_fail++;
                $display("FAIL prio_trace cyc%0d: got %h, expected %h", i, got, expv());
            end
            if (got[5] && got[4:1] != last_step) begin
                seq.push_back(int'(got[4:1]));
                last_step = got[4:1];
            end
        end
        start = 0;
        n_checks++;
        if (seq.size() != 7) begin
            n_fail++;
            $display("FAIL prio_step_count: got %0d, expected 7", seq.size());
        end else begin
            for (int i = 0; i < 7; i++) begin
                n_checks++;
                if (seq[i] != i) begin
                    n_fail++;
                    $display("FAIL prio_step%0d: got %0d, expected %0d", i, seq[i], i);
                end
            end
        end
        $display("test_priority: %0d steps seen", seq.size());
    endtask

    task automatic test_random();
        logic [8:0] got;
        do_reset(0);
        for (int i = 0; i < 3000; i++) begin
            ena = ($urandom_range(0, 3) != 0);
            start = ($urandom_range(0, 15) == 0);
            stop = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 99) == 0) loop = ~loop;
            step_clk();
            got = obs(0);
            n_checks++;
            if (got !== expv()) begin
                n_fail++;
                $display("FAIL random cyc%0d: got %h, expected %h", i, got, expv());
            end
        end
        start = 0; stop = 0; loop = 0; ena = 1;
        $display("test_random: 3000 cycles");
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_full_playback();
        test_looping();
        test_stop();
        test_enable_gating();
        test_priority();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/melody_sequencer.md
# melody_sequencer

Plays a fixed melody by stepping the tone generator's 3-bit note select (`f_ent`) through an internal pattern ROM. Note and gap durations are timed in tempo ticks derived from the audio sample-rate enable. Sits between the front-panel start/stop controls and the tone generator. Owns note timing, sequencing, looping and silencing; it does not touch the NCO or the audio data path.

## Interface
Parameters:
- `TICK_DIV`, 4170: `ena` pulses per tempo tick (0.1 s at 41.7 kHz). Legal range 1..65535.
- `GAP_TICKS`, 1: silent ticks between consecutive notes. 0 means no gap.
- `LEN`, 16: pattern ROM depth. Legal range 1..16.

Ports:
- `clk`  in  1: system clock; all state updates on its rising edge.
- `rst`  in  1: reset, asynchronous, active-high.
- `ena`  in  1: sample-rate enable, one-cycle pulse per audio sample.
- `start`  in  1: level; sampled each cycle; begins playback from IDLE.
- `stop`  in  1: level; sampled each cycle; aborts playback.
- `loop`  in  1: when high at end of pattern, restarts from step 0.
- `f_ent`  out  3: note select driven to the tone generator. 0 means rest.
- `busy`  out  1: high in PLAY or GAP.
- `step`  out  4: current ROM index.
- `done`  out  1: one-cycle pulse at natural end of pattern.

## Operation
ROM entry format: `{note[2:0], dur[4:0]}`. `dur` is in ticks; `dur == 0` is the end marker. Hard-coded contents:

| Step | note | dur |
|---|---|---|
| 0 | 1 | 4 |
| 1 | 2 | 4 |
| 2 | 3 | 4 |
| 3 | 4 | 4 |
| 4 | 3 | 2 |
| 5 | 2 | 2 |
| 6 | 1 | 8 |
| 7 | 0 | 0 (end) |

Entries 8..15 are end markers.

States:
- IDLE: `f_ent = 0`, `step = 0`, `busy = 0`.
  - `start = 1` and `stop = 0` → PLAY, with `step = 0` and the tick counter cleared.
- PLAY: `f_ent = note[step]`. Holds for `dur[step]` ticks.
  - If `GAP_TICKS > 0`, go to GAP.
  - Otherwise advance `step` and evaluate the next entry.
- GAP: `f_ent = 0` for `GAP_TICKS` ticks, then advance `step` and evaluate the next entry.
- Evaluating an entry:
  - If `dur != 0`, go to PLAY.
  - If `dur == 0`, or the step would reach `LEN`, the pattern ends: `done` pulses for 1 cycle.
    - `loop = 1`: return directly to PLAY with `step = 0`.
    - `loop = 0`: go to IDLE.

Arithmetic and counters:
- Tick counter: 16 bits. Increments only on cycles with `ena = 1`.
- On the `ena` cycle where the counter equals `TICK_DIV-1`, it wraps to 0 and asserts an internal `tick`.
- Duration counter: 5 bits. Loaded with `dur` (or `GAP_TICKS`) on entry to PLAY/GAP; decrements on `tick`. The state is left on the `tick` that takes it from 1 to 0.
- Tick and duration counters are cleared on every transition out of IDLE.

Boundary conditions:
- `stop = 1` in any state → IDLE next cycle. `f_ent` goes to 0 and there is no `done` pulse.
- `start` and `stop` high in the same cycle: `stop` wins.
- `start` while `busy` is ignored; there is no restart.
- `ena` held low: all counters freeze and the state holds.
- Step 0 being an end marker: `done` pulses, then IDLE or loop. Step 0 is re-evaluated without playing anything.
- `rst` asserted mid-playback → immediate IDLE values.

## Timing
Reset values: `f_ent = 0`, `busy = 0`, `step = 0`, `done = 0`, state IDLE, all counters 0.

All outputs are registered:
- `start` at edge N → `busy = 1` and `f_ent = note[0]` after edge N+1.
- Note-to-note change occurs on the cycle after the terminating `tick`.
- `done` is high exactly 1 cycle, coincident with the first cycle of IDLE, or of the step 0 PLAY when looping.
- `stop` at edge N → `f_ent = 0` and `busy = 0` after edge N+1.

Note length = `dur × TICK_DIV` `ena` pulses, exact and with no ±1 slop.

## Test plan
- Reset:
  - Stimulus: `rst` pulse mid-run.
  - Required: outputs go to 0/IDLE immediately (asynchronously) and stay until a new `start`.
- Full playback:
  - Setup: `TICK_DIV = 4`, `GAP_TICKS = 1`, `ena = 1` every cycle, `loop = 0`, `start` pulse.
  - Required: `f_ent` sequence 1,0,2,0,3,0,4,0,3,0,2,0,1,0, with note phases lasting 16,16,16,16,8,8,32 cycles and gaps 4 cycles each.
  - Then: `done` pulses once, `busy` falls, and `step` returns to 0.
- Looping:
  - Setup: same as full playback with `loop = 1`, `GAP_TICKS = 0`.
  - Required: after step 6 ends, `done` pulses and `f_ent` returns to 1 on the next cycle, with no IDLE cycle. The pattern repeats for 3 passes.
- Stop:
  - Stimulus: `stop` during step 2 PLAY, then again during a GAP.
  - Required: `f_ent = 0` and `busy = 0` one cycle later, with no `done`. A subsequent `start` restarts from step 0.
- Enable gating:
  - Setup: `ena` every 3rd cycle, `TICK_DIV = 2`.
  - Required: step 0 lasts exactly 8 `ena` pulses (24 cycles).
  - Also: holding `ena` low for 50 cycles freezes `f_ent` and `step`.
- Priority and ignore:
  - Stimulus: `start` and `stop` high together in IDLE, then `start` pulses during playback.
  - Required: the block stays IDLE in the first case. In the second, the `step` sequence is unaffected.
